// File: rtl/exec_ctrl.sv
// -----------------------------------------------------------------------------
// exec_ctrl
// Fetch/decode/execute/writeback sequencer sitting upstream of the alu.
// One instruction is in flight at a time. With zero-wait memory, one
// instruction retires every 4 cycles: FETCH -> DECODE -> EXEC -> WB.
//
// Instruction word: [11:8] opcode, [7:6] rd, [5:4] rs, [3:0] imm
//
// Handshake: instr_req is high only in FETCH while run=1. A word is taken
// on the rising edge where instr_req and instr_valid are both high.
// instr_addr is meaningful only while instr_req=1. The wait for instr_valid
// has no time limit.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 1 = fetch new instructions (honoured only in FETCH)
//   instr_req/addr      fetch request and current PC
//   instr_valid/data    instruction word from program memory
//   alu_op/a/b          registered operands to the alu (held between uses)
//   alu_en              one-cycle alu enable, high in EXEC
//   alu_result          alu registered result, sampled in WB
//   retire              one-cycle pulse in WB
//   z_flag              zero flag of the last writing instruction
//   dbg_state           current FSM state (FETCH=0, DECODE=1, EXEC=2, WB=3)
//
// Optional feature: define EXEC_CTRL_ZFLAG_EN to build the zero-flag
// register. Without it z_flag is tied to 0.
// -----------------------------------------------------------------------------

`ifndef CAP
`define CAP 4
`endif

`ifndef ASM_LDI
`define ASM_LDI  4'h0
`define ASM_CLR  4'h1
`define ASM_SER  4'h2
`define ASM_MOV  4'h3
`define ASM_ADD  4'h4
`define ASM_ADDI 4'h5
`define ASM_INC  4'h6
`define ASM_DEC  4'h7
`define ASM_AND  4'h8
`define ASM_ANDI 4'h9
`define ASM_OR   4'hA
`define ASM_ORI  4'hB
`define ASM_COM  4'hC
`define ASM_EOR  4'hD
`endif

module exec_ctrl #(
    parameter int PC_W   = 8,
    parameter int DATA_W = `CAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic              instr_valid,
    input  logic [11:0]       instr_data,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_en,
    input  logic [DATA_W-1:0] alu_result,
    output logic              retire,
    output logic              z_flag,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PC_W-1:0]   pc_q;
    logic [11:0]       ir_q;
    logic [DATA_W-1:0] rf_q [4];

    // Instruction fields
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] imm;
    logic       op_writes;
    logic       op_uses_imm;

    assign op  = ir_q[11:8];
    assign rd  = ir_q[7:6];
    assign rs  = ir_q[5:4];
    assign imm = ir_q[3:0];

    // Opcodes that write back; everything else retires as a NOP.
    always_comb begin
        op_writes = 1'b0;
        case (op)
            `ASM_LDI, `ASM_CLR, `ASM_SER, `ASM_MOV, `ASM_ADD, `ASM_ADDI,
            `ASM_INC, `ASM_DEC, `ASM_AND, `ASM_ANDI, `ASM_OR, `ASM_ORI,
            `ASM_COM, `ASM_EOR: op_writes = 1'b1;
            default:            op_writes = 1'b0;
        endcase
    end

    // Immediate-form opcodes take operand b from the instruction word.
    always_comb begin
        op_uses_imm = 1'b0;
        case (op)
            `ASM_LDI, `ASM_ADDI, `ASM_ANDI, `ASM_ORI: op_uses_imm = 1'b1;
            default:                                  op_uses_imm = 1'b0;
        endcase
    end

    // Next-state and control outputs
    always_comb begin
        state_d   = state_q;
        instr_req = 1'b0;
        alu_en    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Gated with rst_n so the request drops the instant reset
                // asserts, even though FETCH is also the reset state.
                instr_req = run & rst_n;
                if (run && instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_en  = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, PC, instruction latch, operands and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_FETCH: begin
                    if (run && instr_valid) begin
                        ir_q <= instr_data;
                    end
                end
                S_DECODE: begin
                    // Operands are captured here, before any writeback, so
                    // rd==rs reads the old value.
                    alu_op <= op;
                    alu_a  <= (op == `ASM_MOV) ? rf_q[rs] : rf_q[rd];
                    alu_b  <= op_uses_imm ? DATA_W'(imm) : rf_q[rs];
                end
                S_WB: begin
                    if (op_writes) begin
                        rf_q[rd] <= alu_result;
                    end
                    pc_q <= pc_q + PC_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef EXEC_CTRL_ZFLAG_EN
    logic z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
        end else if (state_q == S_WB && op_writes) begin
            z_q <= (alu_result == '0);
        end
    end

    assign z_flag = z_q;
`else
    assign z_flag = 1'b0;
`endif

    assign instr_addr = pc_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exec_ctrl
// Drives exec_ctrl with directed and random programs. The bench plays both
// program memory and alu. A reference model (register array, PC, zero flag)
// computes what each instruction must do. Written values go through an
// expected queue that is popped when the writeback is observed.
// -----------------------------------------------------------------------------
module tb_exec_ctrl;
  localparam int PC_W   = 8;
  localparam int DATA_W = 4;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_CLR  = 4'h1;
  localparam logic [3:0] OP_SER  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_DEC  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_ANDI = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_ORI  = 4'hB;
  localparam logic [3:0] OP_COM  = 4'hC;
  localparam logic [3:0] OP_EOR  = 4'hD;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              instr_req;
  logic [PC_W-1:0]   instr_addr;
  logic              instr_valid = 1'b0;
  logic [11:0]       instr_data = '0;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_en;
  logic [DATA_W-1:0] alu_result;
  logic              retire;
  logic              z_flag;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exec_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .retire     (retire),
    .z_flag     (z_flag),
    .dbg_state  (dbg_state)
  );

  // ---------------- alu behaviour ----------------
  function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      OP_LDI:          return b;
      OP_CLR:          return 4'h0;
      OP_SER:          return 4'hF;
      OP_MOV:          return a;
      OP_ADD, OP_ADDI: return a + b;
      OP_INC:          return a + 4'd1;
      OP_DEC:          return a - 4'd1;
      OP_AND, OP_ANDI: return a & b;
      OP_OR, OP_ORI:   return a | b;
      OP_COM:          return ~a;
      OP_EOR:          return a ^ b;
      default:         return 4'h5;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_result <= '0;
    else if (alu_en) alu_result <= alu_fn(alu_op, alu_a, alu_b);
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] m_rf [4];
  logic [PC_W-1:0]   m_pc;
  logic              m_z;
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [3:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_pc = '0;
    m_z  = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_rf(input string name);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.rf_q[i] !== m_rf[i]) begin
        errors++;
        $display("FAIL %s: R%0d=%h, want %h", name, i, dut.rf_q[i], m_rf[i]);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Entered at a falling edge with the DUT in FETCH; leaves at a falling
  // edge with the DUT back in FETCH.
  task automatic do_instr(input logic [11:0] ins, input int waits, input bit drop_run,
                          output int ret_cyc);
    logic [3:0] op, ea, eb, er;
    logic [1:0] rd, rs;
    bit wr;
    logic [DATA_W-1:0] got, want;
    op = ins[11:8]; rd = ins[7:6]; rs = ins[5:4];
    ea = (op == OP_MOV) ? m_rf[rs] : m_rf[rd];
    eb = (op == OP_LDI || op == OP_ADDI || op == OP_ANDI || op == OP_ORI) ? ins[3:0] : m_rf[rs];
    er = alu_fn(op, ea, eb);
    wr = (op <= OP_EOR);
    #1;
    checks++;
    if (instr_req !== 1'b1 || instr_addr !== m_pc || alu_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch: req=%b addr=%0d en=%b, want req=1 addr=%0d en=0", instr_req, instr_addr, alu_en, m_pc);
    end
    for (int i = 0; i < waits; i++) begin
      instr_valid = 1'b0;
      instr_data  = 12'($urandom);
      @(negedge clk);
      checks++;
      if (instr_req !== 1'b1 || instr_addr !== m_pc || alu_en !== 1'b0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL fetch_wait: req=%b addr=%0d en=%b st=%0d, want req=1 addr=%0d en=0 st=0",
                 instr_req, instr_addr, alu_en, dbg_state, m_pc);
      end
    end
    instr_valid = 1'b1;
    instr_data  = ins;
    @(negedge clk);                       // DECODE
    instr_valid = 1'b0;
    instr_data  = 12'($urandom);
    checks++;
    if (instr_req !== 1'b0 || alu_en !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL decode: req=%b en=%b ret=%b, want 0 0 0", instr_req, alu_en, retire);
    end
    @(negedge clk);                       // EXEC
    if (drop_run) run = 1'b0;
    checks++;
    if (alu_en !== 1'b1 || alu_op !== op || alu_a !== ea || alu_b !== eb || retire !== 1'b0) begin
      errors++;
      $display("FAIL exec: en=%b op=%h a=%h b=%h ret=%b, want en=1 op=%h a=%h b=%h ret=0",
               alu_en, alu_op, alu_a, alu_b, retire, op, ea, eb);
    end
    @(negedge clk);                       // WB
    ret_cyc = cyc;
    checks++;
    if (retire !== 1'b1 || alu_en !== 1'b0 || instr_req !== 1'b0 ||
        alu_op !== op || alu_a !== ea || alu_b !== eb) begin
      errors++;
      $display("FAIL wb: ret=%b en=%b req=%b op=%h a=%h b=%h, want ret=1 en=0 req=0 op=%h a=%h b=%h",
               retire, alu_en, instr_req, alu_op, alu_a, alu_b, op, ea, eb);
    end
    if (wr) begin
      exp_q.push_back(er);
      m_rf[rd] = er;
`ifdef EXEC_CTRL_ZFLAG_EN
      m_z = (er == '0);
`endif
    end
    m_pc = m_pc + 1'b1;
    @(negedge clk);                       // back in FETCH
    checks++;
    if (retire !== 1'b0 || instr_req !== run || instr_addr !== m_pc || z_flag !== m_z || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL post_wb: ret=%b req=%b addr=%0d z=%b st=%0d, want ret=0 req=%b addr=%0d z=%b st=0",
               retire, instr_req, instr_addr, z_flag, dbg_state, run, m_pc, m_z);
    end
    if (wr) begin
      got  = dut.rf_q[rd];
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL writeback: R%0d=%h, want %h", rd, got, want);
      end
    end
    check_rf("regfile");
    if (drop_run) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (instr_req !== 1'b0 || alu_en !== 1'b0 || dbg_state !== 2'd0 || instr_addr !== m_pc) begin
          errors++;
          $display("FAIL run_low: req=%b en=%b st=%0d addr=%0d, want req=0 en=0 st=0 addr=%0d",
                   instr_req, alu_en, dbg_state, instr_addr, m_pc);
        end
        instr_valid = 1'b1;               // must be ignored while run=0
        @(negedge clk);
      end
      instr_valid = 1'b0;
      run = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    instr_valid = 1'b1;
    instr_data = mk(OP_LDI, 2'd1, 2'd0, 4'd8);
    repeat (2) @(negedge clk);
    checks++;
    if (instr_req !== 1'b0 || instr_addr !== '0 || alu_op !== '0 || alu_a !== '0 || alu_b !== '0 ||
        alu_en !== 1'b0 || retire !== 1'b0 || z_flag !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%0d op=%h a=%h b=%h en=%b ret=%b z=%b st=%0d, want all 0",
               instr_req, instr_addr, alu_op, alu_a, alu_b, alu_en, retire, z_flag, dbg_state);
    end
    model_reset();
    check_rf("reset_rf");
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_ldi();
    int rc;
    do_instr(mk(OP_LDI, 2'd1, 2'd0, 4'd8), 0, 1'b0, rc);
    checks++;
    if (dut.rf_q[1] !== 4'd8 || instr_addr !== 8'd1) begin
      errors++;
      $display("FAIL first_ldi: R1=%h addr=%0d, want R1=8 addr=1", dut.rf_q[1], instr_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] prog [4];
    int rc [4];
    prog[0] = mk(OP_LDI, 2'd0, 2'd0, 4'd1);
    prog[1] = mk(OP_LDI, 2'd1, 2'd0, 4'd8);
    prog[2] = mk(OP_ADD, 2'd0, 2'd1, 4'd0);
    prog[3] = mk(OP_EOR, 2'd0, 2'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      do_instr(prog[i], 0, 1'b0, rc[i]);
      if (i == 2) begin
        checks++;
        if (dut.rf_q[0] !== 4'd9) begin errors++; $display("FAIL add: R0=%h, want 9", dut.rf_q[0]); end
      end
      if (i == 3) begin
        checks++;
        if (dut.rf_q[0] !== 4'd1) begin errors++; $display("FAIL eor: R0=%h, want 1", dut.rf_q[0]); end
      end
      if (i > 0) begin
        checks++;
        if (rc[i] - rc[i-1] != 4) begin
          errors++;
          $display("FAIL retire_gap: %0d cycles, want 4", rc[i] - rc[i-1]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int rc;
    logic [3:0] zs [3];
    do_instr(mk(OP_LDI, 2'd2, 2'd0, 4'd0), 0, 1'b0, rc);
    zs[0] = z_flag;
    do_instr(mk(OP_DEC, 2'd2, 2'd0, 4'd0), 0, 1'b0, rc);
    zs[1] = z_flag;
    checks++;
    if (dut.rf_q[2] !== 4'hF) begin errors++; $display("FAIL dec_wrap: R2=%h, want f", dut.rf_q[2]); end
    do_instr(mk(OP_INC, 2'd2, 2'd0, 4'd0), 0, 1'b0, rc);
    zs[2] = z_flag;
    checks++;
    if (dut.rf_q[2] !== 4'h0) begin errors++; $display("FAIL inc_wrap: R2=%h, want 0", dut.rf_q[2]); end
`ifdef EXEC_CTRL_ZFLAG_EN
    checks++;
    if (zs[0] !== 4'd1 || zs[1] !== 4'd0 || zs[2] !== 4'd1) begin
      errors++;
      $display("FAIL zflag_seq: %0d%0d%0d, want 101", zs[0], zs[1], zs[2]);
    end
`else
    checks++;
    if (zs[0] !== 4'd0 || zs[1] !== 4'd0 || zs[2] !== 4'd0) begin
      errors++;
      $display("FAIL zflag_tied: %0d%0d%0d, want 000", zs[0], zs[1], zs[2]);
    end
`endif
  endtask

  task automatic test_stall_and_run();
    int rc;
    do_instr(mk(OP_ORI, 2'd3, 2'd0, 4'd4), 5, 1'b0, rc);
    do_instr(mk(OP_MOV, 2'd1, 2'd3, 4'd0), 0, 1'b1, rc);
  endtask

  task automatic test_nop();
    int rc;
    logic [PC_W-1:0] pc0;
    do_instr(mk(OP_LDI, 2'd3, 2'd0, 4'd6), 0, 1'b0, rc);
    pc0 = m_pc;
    do_instr(mk(4'hF, 2'd3, 2'd1, 4'hA), 0, 1'b0, rc);
    checks++;
    if (dut.rf_q[3] !== 4'd6 || instr_addr !== pc0 + 1'b1) begin
      errors++;
      $display("FAIL nop: R3=%h addr=%0d, want R3=6 addr=%0d", dut.rf_q[3], instr_addr, pc0 + 1'b1);
    end
  endtask

  task automatic test_midreset();
    test_reset();
    run = 1'b1;
    #1;
    instr_valid = 1'b1;
    instr_data  = mk(OP_ADD, 2'd0, 2'd1, 4'd0);
    @(negedge clk);                       // DECODE
    instr_valid = 1'b0;
    @(negedge clk);                       // EXEC
    checks++;
    if (alu_en !== 1'b1) begin errors++; $display("FAIL midreset_exec: en=%b, want 1", alu_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (instr_req !== 1'b0 || instr_addr !== '0 || alu_op !== '0 || alu_a !== '0 || alu_b !== '0 ||
        alu_en !== 1'b0 || retire !== 1'b0 || z_flag !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_outputs: req=%b addr=%0d op=%h a=%h b=%h en=%b ret=%b z=%b st=%0d, want all 0",
               instr_req, instr_addr, alu_op, alu_a, alu_b, alu_en, retire, z_flag, dbg_state);
    end
    model_reset();
    check_rf("midreset_rf");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_rf("after_midreset_rf");
  endtask

  task automatic test_random();
    int rc;
    logic [11:0] ins;
    for (int n = 0; n < 300; n++) begin
      ins = 12'($urandom);
      do_instr(ins, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
               ($urandom_range(0, 9) == 0), rc);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_ldi();
    test_back_to_back();
    test_wrap();
    test_stall_and_run();
    test_nop();
    test_midreset();
    test_first_ldi();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
